mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL expose parameter ADDR_WIDTH, default 32, meaning the RAM and request address width.
REQ-002 SHALL expose: clk  in  1  system clock; all state updates on its rising edge.
REQ-003 SHALL expose: rst  in  1  asynchronous, active-low reset.
REQ-004 SHALL expose: ena  in  1  global enable; low means all registers hold and out_ram_wr is forced 0.
REQ-005 SHALL expose: in_rollback  in  1  misbranch flush pulse.
REQ-006 SHALL expose: in_fetch_ena  in  1  one-cycle fetch request pulse; in_fetch_addr  in  ADDR_WIDTH  instruction address.
REQ-007 SHALL expose: out_fetch_ready  out  1  fetch done pulse; out_fetch_data  out  32  instruction word.
REQ-008 SHALL expose: in_ls_ena  in  1  one-cycle LSqueue request pulse; in_ls_iswrite  in  1  store when 1; in_ls_size  in  3  byte count (1, 2 or 4).
REQ-009 SHALL expose: in_ls_addr  in  ADDR_WIDTH  data address; in_ls_write_data  in  32  store data, low bytes used.
REQ-010 SHALL expose: out_ls_ready  out  1  LS done pulse; out_ls_read_data  out  32  zero-extended load bytes.
REQ-011 SHALL expose: in_ram_data  in  8  RAM read byte; out_ram_data  out  8  write byte; out_ram_addr  out  ADDR_WIDTH  byte address; out_ram_wr  out  1  write strobe.

Function
REQ-012 SHALL latch each request pulse into a pending slot (fetch, ls), holding address, size, direction and data until served.
REQ-013 SHALL use states IDLE, LS_READ, LS_WRITE, FETCH, plus a 3-bit byte counter.
REQ-014 In IDLE with both slots pending, SHALL serve ls first; a fetch SHALL never preempt a transfer in flight.
REQ-015 Reads SHALL drive address base+k for k=0..n-1 on consecutive cycles, capture byte k one cycle later, and place byte k at bits [8k+7:8k], little-endian.
REQ-016 Read ready SHALL pulse exactly n+2 edges after the edge sampling the request, given IDLE and no competing ls; fetch therefore has latency 6 and LB latency 3.
REQ-017 Writes SHALL drive base+k with out_ram_wr=1 and out_ram_data=write_data[8k+7:8k] for k=0..n-1; out_ls_ready SHALL pulse n+1 edges after sampling.
REQ-018 out_*_ready SHALL be high for exactly one cycle; the matching data output SHALL be valid in that cycle and 0 otherwise.
REQ-019 out_ram_wr SHALL be 0 in every cycle not driving a store byte.
REQ-020 On return to IDLE, a still-pending slot SHALL start on the next edge; there are no idle bubble cycles beyond this.
REQ-021 On in_rollback (ena high), SHALL abort FETCH and LS_READ, clear the fetch and ls-read pending slots, and suppress their ready pulses.
REQ-022 On in_rollback, an LS_WRITE in flight or pending SHALL complete normally, because stores are already committed.
REQ-023 A fetch request in the rollback cycle SHALL be accepted as the redirected fetch.
REQ-024 A request arriving while its own slot is pending or in flight is a protocol error and SHALL be ignored.

Reset
REQ-025 While rst=0: state IDLE, counter 0, both slots cleared, and all outputs 0 (out_ram_addr 0, out_ram_wr 0, ready 0, data 0).
REQ-026 Reset asserted mid-transfer SHALL abandon the transfer with no ready pulse; the first request after release SHALL behave as from cold.

Verification
REQ-027 Fetch at 0x1000, RAM bytes 13,00,00,00 -> out_ram_addr 0x1000..0x1003 on consecutive cycles; out_fetch_ready at edge 6 with data 0x00000013.
REQ-028 Same-cycle fetch 0x0 and LW at 0x20 (RAM 78,56,34,12) -> ls served first, ls data 0x12345678 at edge 6, fetch ready at edge 12.
REQ-029 SB 0xAB at 0x30 -> exactly one out_ram_wr cycle, addr 0x30, data 0xAB; out_ls_ready at edge 2.
REQ-030 SW 0xDEADBEEF at 0x40, rollback at edge 2 -> bytes EF,BE,AD,DE still written to 0x40..0x43 and ls ready pulses; a concurrent pending fetch is dropped.
REQ-031 Fetch in progress, rollback with new fetch 0x200 in the same cycle -> no ready for the old fetch; 0x200 served, ready 6 edges later.
REQ-032 ena low for 3 cycles mid-LW -> out_ram_wr 0 and all state held; result and latency are shifted by exactly 3 edges.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide synchronous RAM between instruction fetch and the load/store queue
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic                  in_rollback,
    input  logic                  in_fetch_ena,
    input  logic [ADDR_WIDTH-1:0] in_fetch_addr,
    output logic                  out_fetch_ready,
    output logic [31:0]           out_fetch_data,
    input  logic                  in_ls_ena,
    input  logic                  in_ls_iswrite,
    input  logic [2:0]            in_ls_size,
    input  logic [ADDR_WIDTH-1:0] in_ls_addr,
    input  logic [31:0]           in_ls_write_data,
    output logic                  out_ls_ready,
    output logic [31:0]           out_ls_read_data,
    input  logic [7:0]            in_ram_data,
    output logic [7:0]            out_ram_data,
    output logic [ADDR_WIDTH-1:0] out_ram_addr,
    output logic                  out_ram_wr
);
    typedef enum logic [1:0] {IDLE, LS_READ, LS_WRITE, FETCH} state_t;

    state_t                state, state_nxt;
    logic [2:0]            cnt, cnt_nxt;
    logic                  fetch_pend, fetch_pend_nxt;
    logic [ADDR_WIDTH-1:0] fetch_addr, fetch_addr_nxt;
    logic                  ls_pend, ls_pend_nxt;
    logic                  ls_wr, ls_wr_nxt;
    logic [2:0]            ls_size, ls_size_nxt;
    logic [ADDR_WIDTH-1:0] ls_addr, ls_addr_nxt;
    logic [31:0]           ls_wdata, ls_wdata_nxt;
    logic [31:0]           acc, acc_nxt;
    logic                  fetch_ready_nxt, ls_ready_nxt;
    logic [31:0]           fetch_data_nxt, ls_data_nxt;
    logic [2:0]            len, off;
    logic [ADDR_WIDTH-1:0] base;
    logic [31:0]           merged;

    // RAM-side drive; while stalled on a read the previous byte address is re-presented so the byte awaiting capture survives the stall
    always_comb begin
        len          = (state == FETCH) ? 3'd4 : ls_size;
        off          = (!ena && cnt != 3'd0 && state != LS_WRITE) ? cnt - 3'd1 : cnt;
        base         = (state == FETCH) ? fetch_addr : ls_addr;
        merged       = acc | ({24'd0, in_ram_data} << {cnt - 3'd1, 3'b000});
        out_ram_addr = (state == IDLE) ? '0 : base + ADDR_WIDTH'(off);
        out_ram_wr   = ena && state == LS_WRITE;
        out_ram_data = out_ram_wr ? 8'(ls_wdata >> {cnt, 3'b000}) : 8'd0;
    end

    // Arbitration (ls before fetch), byte sequencing, rollback flush and request capture
    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        acc_nxt         = acc;
        fetch_pend_nxt  = fetch_pend;
        fetch_addr_nxt  = fetch_addr;
        ls_pend_nxt     = ls_pend;
        ls_wr_nxt       = ls_wr;
        ls_size_nxt     = ls_size;
        ls_addr_nxt     = ls_addr;
        ls_wdata_nxt    = ls_wdata;
        fetch_ready_nxt = 1'b0;
        ls_ready_nxt    = 1'b0;
        fetch_data_nxt  = '0;
        ls_data_nxt     = '0;
        case (state)
            IDLE: begin
                cnt_nxt = 3'd0;
                acc_nxt = '0;
                if (ls_pend && (ls_wr || !in_rollback))
                    state_nxt = ls_wr ? LS_WRITE : LS_READ;
                else if (fetch_pend && !in_rollback)
                    state_nxt = FETCH;
            end
            LS_WRITE: begin
                cnt_nxt = cnt + 3'd1;
                if (cnt == len - 3'd1) begin
                    state_nxt    = IDLE;
                    ls_pend_nxt  = 1'b0;
                    ls_ready_nxt = 1'b1;
                end
            end
            default: begin
                cnt_nxt = cnt + 3'd1;
                if (cnt != 3'd0)
                    acc_nxt = merged;
                if (cnt == len) begin
                    state_nxt = IDLE;
                    if (state == FETCH) begin
                        fetch_pend_nxt  = 1'b0;
                        fetch_ready_nxt = 1'b1;
                        fetch_data_nxt  = merged;
                    end else begin
                        ls_pend_nxt  = 1'b0;
                        ls_ready_nxt = 1'b1;
                        ls_data_nxt  = merged;
                    end
                end
            end
        endcase
        if (in_rollback) begin
            fetch_pend_nxt  = 1'b0;
            fetch_ready_nxt = 1'b0;
            fetch_data_nxt  = '0;
            if (!ls_wr) begin
                ls_pend_nxt  = 1'b0;
                ls_ready_nxt = 1'b0;
                ls_data_nxt  = '0;
            end
            if (state == FETCH || state == LS_READ)
                state_nxt = IDLE;
        end
        if (in_fetch_ena && (!fetch_pend || in_rollback)) begin
            fetch_pend_nxt = 1'b1;
            fetch_addr_nxt = in_fetch_addr;
        end
        if (in_ls_ena && !ls_pend) begin
            ls_pend_nxt  = 1'b1;
            ls_wr_nxt    = in_ls_iswrite;
            ls_size_nxt  = in_ls_size;
            ls_addr_nxt  = in_ls_addr;
            ls_wdata_nxt = in_ls_write_data;
        end
    end

    // State and output registers; everything freezes while ena is low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            cnt              <= 3'd0;
            fetch_pend       <= 1'b0;
            fetch_addr       <= '0;
            ls_pend          <= 1'b0;
            ls_wr            <= 1'b0;
            ls_size          <= 3'd0;
            ls_addr          <= '0;
            ls_wdata         <= '0;
            acc              <= '0;
            out_fetch_ready  <= 1'b0;
            out_fetch_data   <= '0;
            out_ls_ready     <= 1'b0;
            out_ls_read_data <= '0;
        end else if (ena) begin
            state            <= state_nxt;
            cnt              <= cnt_nxt;
            fetch_pend       <= fetch_pend_nxt;
            fetch_addr       <= fetch_addr_nxt;
            ls_pend          <= ls_pend_nxt;
            ls_wr            <= ls_wr_nxt;
            ls_size          <= ls_size_nxt;
            ls_addr          <= ls_addr_nxt;
            ls_wdata         <= ls_wdata_nxt;
            acc              <= acc_nxt;
            out_fetch_ready  <= fetch_ready_nxt;
            out_fetch_data   <= fetch_data_nxt;
            out_ls_ready     <= ls_ready_nxt;
            out_ls_read_data <= ls_data_nxt;
        end
    end
endmodule
